bus_arbiter4way16: RTL
======================

# bus_arbiter4way16

Round-robin arbiter that shares one 16-bit datapath between four requesters. It drives the 2-bit select of an internal MUX4WAY16 and registers the selected word onto a single output bus. It sits in front of any shared 16-bit consumer (memory write port, ALU operand bus), replacing the static select line with a request/grant handshake.

## Interface
- MAX_HOLD, 8: maximum consecutive cycles one requester keeps the grant while others are waiting; legal range 1..255. Used only with ARB_TIMEOUT_EN.
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-high reset
- REQ  input  4  request lines; bit i belongs to requester i
- A, B, C, D  input  16 each  data words of requesters 0, 1, 2, 3
- GNT  output  4  one-hot grant, or all zero when idle; registered
- SEL  output  2  index of current/last owner; drives the MUX4WAY16 select; registered
- Y  output  16  registered selected data word
- VALID  output  1  Y holds a word captured from the owner during a granted cycle

## Operation
- States: IDLE (GNT=0) and GRANT (exactly one GNT bit set; owner = SEL).
- Round-robin pointer LAST holds the most recent owner. Search order for a new owner is LAST+1, LAST+2, LAST+3, LAST (mod 4). The first requester found with REQ high wins.
- IDLE: if REQ≠0, choose a winner, set GNT/SEL, go to GRANT. Otherwise stay.
- GRANT, owner k:
  - REQ[k] high and no forced rotation: hold the grant.
  - REQ[k] low: release. If any other REQ is high, hand over directly on the same edge to the next winner, with no idle bubble. Otherwise go to IDLE. SEL keeps k. LAST becomes k.
  - Forced rotation (ARB_TIMEOUT_EN only): same as release, but k is excluded from the search on that edge.
- Data capture: on each edge, if the pre-edge state is GRANT with owner k and REQ[k] is high, then Y <= word k and VALID <= 1. Otherwise VALID <= 0 and Y holds its value.
- REQ changes from non-owners never disturb the current grant.

## Timing
- Reset values (asynchronous): GNT=0, SEL=0, Y=16'h0000, VALID=0, LAST=3 so requester 0 wins first, hold counter=0, state IDLE.
- Grant latency: REQ sampled high at edge n gives GNT valid after edge n (one cycle from request to grant).
- Data latency: the first VALID word appears after edge n+1. Y is the owner's data as sampled at that edge. VALID lags GNT by one cycle.
- Release: owner drops REQ before edge m. After edge m, GNT moves to the new owner or to 0, and VALID=0 for that cycle. The new owner's first word is valid after edge m+1.
- Simultaneous requests: resolved purely by pointer order. With all four requesting from reset and each holding for one word, the grant order is 0, 1, 2, 3, 0.
- RESET asserted mid-grant: all outputs clear immediately, with no wait for a clock edge. The arbiter restarts from requester 0 priority.

## Configuration
- Macro ARB_TIMEOUT_EN.
- Defined: an 8-bit hold counter clears on every new grant and increments on each held cycle.
  - When the counter reaches MAX_HOLD−1 and any other REQ is high, the next edge forces rotation.
  - If no other request is pending, the owner keeps the grant and the counter clears.
- Undefined: no counter, and MAX_HOLD is ignored. The owner keeps the grant until its REQ drops, so a requester can starve the others.

## Test plan
- Reset then single requester: REQ=4'b0100, C=16'h00F0. GNT=4'b0100 and SEL=2 after 1 edge. Y=16'h00F0 and VALID=1 after 2 edges.
- All request from reset, A..D=F000/0F00/00F0/000F, each requester drops REQ one cycle after its grant. GNT order is 0001, 0010, 0100, 1000. Y follows F000, 0F00, 00F0, 000F with VALID pulsing once per owner.
- Handover without bubble: owner 1 drops REQ while REQ[3] is high. On the same edge GNT goes 0010 to 1000, VALID=0 for one cycle, then Y=16'h000F.
- Release to idle: the sole owner drops REQ. GNT=0 and VALID=0 next edge, SEL and Y hold their last values.
- ARB_TIMEOUT_EN with MAX_HOLD=4: REQ[0] and REQ[2] held high continuously. GNT alternates 0001 and 0100 every 4 cycles. With only REQ[0] high, GNT stays 0001 indefinitely.
- Async reset mid-grant: assert RESET between edges. GNT, SEL, Y and VALID read 0 before the next CLK edge. After release, requester 0 wins first.

Source files
------------

// File: rtl/bus_arbiter4way16_if.sv
// Request/grant and data bus between four requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface bus_arbiter4way16_if;
    logic [3:0]  REQ;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] C;
    logic [15:0] D;
    logic [3:0]  GNT;
    logic [1:0]  SEL;
    logic [15:0] Y;
    logic        VALID;

    modport master (
        output REQ, A, B, C, D,
        input  GNT, SEL, Y, VALID
    );

    modport slave (
        input  REQ, A, B, C, D,
        output GNT, SEL, Y, VALID
    );
endinterface

// File: rtl/bus_arbiter4way16.sv
// Four-way round-robin arbiter driving a MUX4WAY16 select and a registered 16-bit output.
// Optional hold-limit rotation is enabled by defining ARB_TIMEOUT_EN.
//
// Handshake: REQ[i] is held high by requester i for as long as it wants the bus;
// GNT is one-hot for the owner (registered), and every cycle the owner's REQ is
// high during a granted cycle its word is captured into Y with VALID high on the
// following cycle. Dropping REQ releases the bus on the next edge.
module bus_arbiter4way16 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    bus_arbiter4way16_if.slave bus,
    output logic              state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..255");
    end

    state_t      state_q, state_n;
    logic [3:0]  gnt_q, gnt_n;
    logic [1:0]  sel_q, sel_n;
    logic [1:0]  last_q, last_n;
    logic [15:0] y_q;
    logic        valid_q;
    logic [15:0] mux_word;
    logic        owner_req;
    logic [3:0]  others;
    logic        force_rot;
    logic [2:0]  pick_idle;
    logic [2:0]  pick_hand;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);
    logic [7:0]  hold_q, hold_n;
`endif

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Returns {found, index}; scans from last+1 around to last itself.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic       found;
        logic [1:0] idx;
        logic [1:0] j;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            j = last + 2'(i);
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
        return {found, idx};
    endfunction

    // MUX4WAY16 steered by the registered select.
    always_comb begin
        mux_word = bus.A;
        case (sel_q)
            2'd0: mux_word = bus.A;
            2'd1: mux_word = bus.B;
            2'd2: mux_word = bus.C;
            2'd3: mux_word = bus.D;
            default: mux_word = bus.A;
        endcase
    end

    assign owner_req = bus.REQ[sel_q];
    assign others    = bus.REQ & ~onehot(sel_q);
    assign pick_idle = rr_pick(bus.REQ, last_q);
    assign pick_hand = rr_pick(others, sel_q);

    always_comb begin
        state_n   = state_q;
        gnt_n     = gnt_q;
        sel_n     = sel_q;
        last_n    = last_q;
        force_rot = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_n    = hold_q;
        force_rot = (hold_q == HOLD_LIMIT) && (others != 4'b0000);
`endif
        case (state_q)
            IDLE: begin
                if (bus.REQ != 4'b0000) begin
                    state_n = GRANT;
                    gnt_n   = onehot(pick_idle[1:0]);
                    sel_n   = pick_idle[1:0];
`ifdef ARB_TIMEOUT_EN
                    hold_n  = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (owner_req && !force_rot) begin
`ifdef ARB_TIMEOUT_EN
                    // Reaching the limit with nobody waiting just restarts the count.
                    hold_n = (hold_q == HOLD_LIMIT) ? 8'd0 : hold_q + 8'd1;
`endif
                end else begin
                    // Release or forced rotation: the current owner is never re-picked here.
                    last_n = sel_q;
`ifdef ARB_TIMEOUT_EN
                    hold_n = 8'd0;
`endif
                    if (pick_hand[2]) begin
                        gnt_n = onehot(pick_hand[1:0]);
                        sel_n = pick_hand[1:0];
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 4'b0000;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            y_q     <= 16'h0000;
            valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_n;
            gnt_q   <= gnt_n;
            sel_q   <= sel_n;
            last_q  <= last_n;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= hold_n;
`endif
            // Capture uses the pre-edge owner, so VALID trails GNT by one cycle.
            if (state_q == GRANT && owner_req) begin
                y_q     <= mux_word;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.GNT   = gnt_q;
    assign bus.SEL   = sel_q;
    assign bus.Y     = y_q;
    assign bus.VALID = valid_q;
    assign state_dbg = (state_q == GRANT);

endmodule
